// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg -- shared CPU defines for the HI/LO multiply/divide unit.
// Holds the operation codes, the FSM state encoding and the constant
// quotient produced by a divide by zero.
package hilo_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    // Divide by zero: LO gets all ones (sliced to DATA_W), HI gets the dividend.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    function automatic logic op_valid(input logic [2:0] code);
        return code <= 3'(OP_MTLO);
    endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// div_core -- radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands (setup cycle)
//   cancel          abort the running division
//   is_signed       treat dividend/divisor as two's complement
//   dividend        operand A
//   divisor         operand B
//   last            high during the final iteration; quotient/remainder valid
//   quotient        final quotient (sign-corrected), valid while last=1
//   remainder       final remainder (sign-corrected), valid while last=1
module div_core
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cancel,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CW = $clog2(DATA_W);

    logic              active;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic              neg_q, neg_r, div0;

    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   rem_sh, diff;
    logic [DATA_W-1:0] rem_n, quo_n;

    // Magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
    assign abs_a = (is_signed && dividend[DATA_W-1]) ? -dividend : dividend;
    assign abs_b = (is_signed && divisor[DATA_W-1])  ? -divisor  : divisor;

    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[DATA_W]) begin
            rem_n = diff[DATA_W-1:0];
            quo_n = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[DATA_W-1:0];
            quo_n = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    assign last      = active && (cnt == CW'(DATA_W - 1));
    // Results are taken from the final iteration's next-state values so the
    // caller can write them on the same edge that completes the division.
    assign quotient  = div0  ? DIV0_QUOTIENT[DATA_W-1:0] : (neg_q ? -quo_n : quo_n);
    assign remainder = neg_r ? -rem_n : rem_n;

    always_ff @(posedge clk) begin
        if (rst || cancel) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= abs_a;
            dvs_q  <= abs_b;
            neg_q  <= is_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_r  <= is_signed && dividend[DATA_W-1];
            div0   <= (divisor == '0);
        end else if (active) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt + 1'b1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- MIPS-style HI/LO multiply/divide unit.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      request strobe, accepted only while busy=0
//   op         MULT, MULTU, DIV, DIVU, MTHI, MTLO (other codes ignored)
//   a, b       operands (a = dividend and MTHI/MTLO source, b = divisor)
//   cancel     flush: aborts any in-flight operation, blocks a same-cycle start
//   busy       multi-cycle operation in flight
//   done       one-cycle pulse in the first cycle HI/LO show a new result
//   hi, lo     HI/LO registers; hilo = {hi, lo}
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cancel,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic [2*DATA_W-1:0] hilo
);

    // Product pipeline stages between the operand register and HI/LO.
    localparam int         PD       = (MUL_LAT >= 3) ? MUL_LAT - 2 : 1;
    localparam logic [1:0] MUL_LAST = 2'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);

    state_t              state, state_n;
    logic                accept, acc_mul, acc_div, acc_mthi, acc_mtlo;
    logic                done_n;
    logic [DATA_W-1:0]   hi_n, lo_n;

    logic [DATA_W-1:0]   ma_q, mb_q;
    logic                ms_q;
    logic [1:0]          mul_cnt;
    logic [2*DATA_W-1:0] ext_a_in, ext_b_in, in_prod;
    logic [2*DATA_W-1:0] ext_a_q, ext_b_q, prod, mul_res;
    logic [2*DATA_W-1:0] mpipe [PD];

    logic                div_last;
    logic [DATA_W-1:0]   div_quo, div_rem;

    // Sign- or zero-extending to 2*DATA_W makes one truncated multiply
    // correct for both MULT and MULTU.
    assign ext_a_in = {{DATA_W{(op == OP_MULT) & a[DATA_W-1]}}, a};
    assign ext_b_in = {{DATA_W{(op == OP_MULT) & b[DATA_W-1]}}, b};
    assign in_prod  = ext_a_in * ext_b_in;
    assign ext_a_q  = {{DATA_W{ms_q & ma_q[DATA_W-1]}}, ma_q};
    assign ext_b_q  = {{DATA_W{ms_q & mb_q[DATA_W-1]}}, mb_q};
    assign prod     = ext_a_q * ext_b_q;
    assign mul_res  = (MUL_LAT >= 3) ? mpipe[PD-1] : prod;

    assign hilo = {hi, lo};

    div_core #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (acc_div),
        .cancel    (cancel),
        .is_signed (op == OP_DIV),
        .dividend  (a),
        .divisor   (b),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_n  = state;
        done_n   = 1'b0;
        hi_n     = hi;
        lo_n     = lo;
        busy     = (state != IDLE);
        accept   = start && !busy && !cancel && op_valid(op);
        acc_mul  = accept && ((op == OP_MULT) || (op == OP_MULTU));
        acc_div  = accept && ((op == OP_DIV) || (op == OP_DIVU));
        acc_mthi = accept && (op == OP_MTHI);
        acc_mtlo = accept && (op == OP_MTLO);
        case (state)
            IDLE: begin
                if (acc_mul) begin
                    // Single-cycle multiply writes straight from the inputs.
                    if (MUL_LAT == 1) begin
                        {hi_n, lo_n} = in_prod;
                        done_n       = 1'b1;
                    end else begin
                        state_n = MUL;
                    end
                end
                if (acc_div) begin
                    state_n = DIV;
                end
                if (acc_mthi) begin
                    hi_n   = a;
                    done_n = 1'b1;
                end
                if (acc_mtlo) begin
                    lo_n   = a;
                    done_n = 1'b1;
                end
            end
            MUL: begin
                if (cancel) begin
                    state_n = IDLE;
                end else if (mul_cnt == MUL_LAST) begin
                    state_n      = IDLE;
                    {hi_n, lo_n} = mul_res;
                    done_n       = 1'b1;
                end
            end
            DIV: begin
                if (cancel) begin
                    state_n = IDLE;
                end else if (div_last) begin
                    state_n = IDLE;
                    lo_n    = div_quo;
                    hi_n    = div_rem;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            mul_cnt <= '0;
        end else begin
            hi      <= hi_n;
            lo      <= lo_n;
            done    <= done_n;
            mul_cnt <= (state == MUL) ? mul_cnt + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_mul) begin
            ma_q <= a;
            mb_q <= b;
            ms_q <= (op == OP_MULT);
        end
        mpipe[0] <= prod;
        for (int unsigned i = 1; i < PD; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv -- self-checking bench for hilo_muldiv (DATA_W=32, MUL_LAT=2).
module tb_hilo_muldiv;

    localparam int W  = 32;
    localparam int ML = 2;
    localparam int DL = W + 1;

    localparam logic [2:0] C_MULT  = 3'd0;
    localparam logic [2:0] C_MULTU = 3'd1;
    localparam logic [2:0] C_DIV   = 3'd2;
    localparam logic [2:0] C_DIVU  = 3'd3;
    localparam logic [2:0] C_MTHI  = 3'd4;
    localparam logic [2:0] C_MTLO  = 3'd5;

    logic           clk = 1'b0;
    logic           rst, start, cancel;
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [W-1:0]   hi, lo;
    logic [2*W-1:0] hilo;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] m_hi, m_lo;

    hilo_muldiv #(
        .DATA_W  (W),
        .MUL_LAT (ML)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .hilo   (hilo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [2:0] o);
        if (o == C_MULT || o == C_MULTU) return ML;
        if (o == C_DIV || o == C_DIVU) return DL;
        return 1;
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model_apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint         sx, sy, sp, q, r;
        logic [2*W-1:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            C_MULT: begin
                sp = sx * sy;
                p  = sp;
                {m_hi, m_lo} = p;
            end
            C_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                {m_hi, m_lo} = p;
            end
            C_DIV: begin
                if (y == 0) begin
                    m_lo = '1;
                    m_hi = x;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = W'(q);
                    m_hi = W'(r);
                end
            end
            C_DIVU: begin
                if (y == 0) begin
                    m_lo = '1;
                    m_hi = x;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            C_MTHI: m_hi = x;
            C_MTLO: m_lo = x;
            default: ;
        endcase
    endtask

    // Issues one request and waits (bounded) for done; lat = cycles from accept.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        tick();
        tick();
        n_total++; if (hi !== '0) $display("FAIL reset_hi: got %h expected 0", hi); else n_pass++;
        n_total++; if (lo !== '0) $display("FAIL reset_lo: got %h expected 0", lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_vectors();
        int lat;
        op = C_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL mult_k1: busy=%b done=%b expected busy=1 done=0", busy, done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL mult_k2: done=%b busy=%b expected done=1 busy=0", done, busy); else n_pass++;
        n_total++; if (hilo !== 64'hFFFF_FFFF_FFFF_FFFA)
            $display("FAIL mult_hilo: got %h expected ffffffff_fffffffa", hilo); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b expected 0", done); else n_pass++;
        model_apply(C_MULT, 32'hFFFF_FFFE, 32'd3);

        do_op(C_MULTU, 32'hFFFF_FFFE, 32'd3, lat);
        model_apply(C_MULTU, 32'hFFFF_FFFE, 32'd3);
        n_total++; if (lat != ML) $display("FAIL multu_lat: got %0d expected %0d", lat, ML); else n_pass++;
        n_total++; if (hi !== 32'h2) $display("FAIL multu_hi: got %h expected 00000002", hi); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL multu_lo: got %h expected fffffffa", lo); else n_pass++;

        do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, lat);
        model_apply(C_DIV, 32'hFFFF_FFF9, 32'd2);
        n_total++; if (lat != DL) $display("FAIL div_lat: got %0d expected %0d", lat, DL); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", lo); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", hi); else n_pass++;

        do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        model_apply(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        n_total++; if (lo !== 32'h8000_0000) $display("FAIL divmin_lo: got %h expected 80000000", lo); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL divmin_hi: got %h expected 00000000", hi); else n_pass++;

        do_op(C_DIVU, 32'h1234, 32'h0, lat);
        model_apply(C_DIVU, 32'h1234, 32'h0);
        n_total++; if (lat != DL) $display("FAIL div0_lat: got %0d expected %0d", lat, DL); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h expected ffffffff", lo); else n_pass++;
        n_total++; if (hi !== 32'h1234) $display("FAIL div0_hi: got %h expected 00001234", hi); else n_pass++;

        do_op(C_DIV, 32'hFFFF_FFF9, 32'h0, lat);
        model_apply(C_DIV, 32'hFFFF_FFF9, 32'h0);
        n_total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9)
            $display("FAIL sdiv0: got hi=%h lo=%h expected hi=fffffff9 lo=ffffffff", hi, lo); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int           lat, el;
        logic [2:0]   o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 5));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            el = exp_lat(o);
            model_apply(o, x, y);
            do_op(o, x, y, lat);
            n_total++; if (lat != el) $display("FAIL rand_lat[%0d] op=%0d: got %0d expected %0d", i, o, lat, el); else n_pass++;
            n_total++; if (hi !== m_hi) $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, hi, m_hi); else n_pass++;
            n_total++; if (lo !== m_lo) $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, lo, m_lo); else n_pass++;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        do_op(C_DIVU, 32'd100, 32'd7, lat1);
        model_apply(C_DIVU, 32'd100, 32'd7);
        n_total++; if (lo !== 32'd14 || hi !== 32'd2)
            $display("FAIL b2b_div: got hi=%h lo=%h expected hi=2 lo=e", hi, lo); else n_pass++;
        // Issued in the done cycle of the divide.
        do_op(C_MULTU, 32'h0001_0000, 32'h0001_0000, lat2);
        model_apply(C_MULTU, 32'h0001_0000, 32'h0001_0000);
        n_total++; if (lat2 != ML) $display("FAIL b2b_mul_lat: got %0d expected %0d", lat2, ML); else n_pass++;
        n_total++; if (hi !== 32'h1 || lo !== 32'h0)
            $display("FAIL b2b_mul: got hi=%h lo=%h expected hi=1 lo=0", hi, lo); else n_pass++;
        tick();
    endtask

    task automatic test_ignored();
        int lat;
        op = C_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        op = C_MTLO; a = 32'hDEAD_BEEF;
        lat = 1;
        repeat (5) begin
            tick();
            lat++;
        end
        start = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        model_apply(C_DIVU, 32'd1000, 32'd3);
        n_total++; if (lat != DL) $display("FAIL busy_start_lat: got %0d expected %0d", lat, DL); else n_pass++;
        n_total++; if (lo !== 32'd333 || hi !== 32'd1)
            $display("FAIL busy_start_result: got hi=%h lo=%h expected hi=1 lo=14d", hi, lo); else n_pass++;
        tick();
        n_total++; if (lo !== 32'd333 || done !== 1'b0)
            $display("FAIL busy_start_queued: got lo=%h done=%b expected lo=14d done=0", lo, done); else n_pass++;

        op = 3'd6; a = 32'h5555_5555; b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL badop_busy: got %b expected 0", busy); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0 || hi !== m_hi || lo !== m_lo)
            $display("FAIL badop_state: got done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h", done, hi, lo, m_hi, m_lo); else n_pass++;
    endtask

    task automatic test_cancel();
        int lat;
        bit seen;
        op = C_DIV; a = $urandom; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL cancel_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (hi !== m_hi || lo !== m_lo)
            $display("FAIL cancel_hilo: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, m_hi, m_lo); else n_pass++;
        seen = 1'b0;
        repeat (40) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        n_total++; if (seen) $display("FAIL cancel_no_done: got done pulse expected none"); else n_pass++;

        do_op(C_MTHI, 32'hA5A5_A5A5, 32'h0, lat);
        model_apply(C_MTHI, 32'hA5A5_A5A5, 32'h0);
        n_total++; if (lat != 1) $display("FAIL mthi_lat: got %0d expected 1", lat); else n_pass++;
        n_total++; if (hi !== 32'hA5A5_A5A5 || lo !== m_lo)
            $display("FAIL mthi: got hi=%h lo=%h expected hi=a5a5a5a5 lo=%h", hi, lo, m_lo); else n_pass++;
        tick();

        op = C_MTLO; a = 32'h1234_5678; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        n_total++; if (lo !== m_lo || busy !== 1'b0)
            $display("FAIL cancel_start: got lo=%h busy=%b expected lo=%h busy=0", lo, busy, m_lo); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL cancel_start_done: got %b expected 0", done); else n_pass++;

        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_total++; if (hi !== m_hi || lo !== m_lo)
            $display("FAIL cancel_idle: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, m_hi, m_lo); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        op = C_MULT; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        n_total++; if (hilo !== '0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid: got hilo=%h busy=%b done=%b expected all 0", hilo, busy, done); else n_pass++;
        seen = 1'b0;
        repeat (6) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        n_total++; if (seen || hilo !== '0)
            $display("FAIL rst_mid_after: got done_seen=%b hilo=%h expected 0 and 0", seen, hilo); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_ignored();
        test_cancel();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter DATA_W, default 32, operand and HI/LO width; legal values 8..64, even.
REQ-002 Parameter MUL_LAT, default 2, multiply latency in cycles; legal 1..4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request strobe; sampled only when busy=0.
REQ-006 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 a  input  DATA_W  operand A, the dividend; the only source for MTHI/MTLO.
REQ-008 b  input  DATA_W  operand B, the divisor.
REQ-009 cancel  input  1  pipeline flush; aborts any in-flight operation.
REQ-010 busy  output  1  multi-cycle operation in flight.
REQ-011 done  output  1  one-cycle pulse, high in the cycle HI/LO first show a new result.
REQ-012 hi  output  DATA_W  HI register.
REQ-013 lo  output  DATA_W  LO register.
REQ-014 hilo  output  2*DATA_W  {hi,lo}.

Function
REQ-015 FSM states: IDLE, MUL, DIV; state changes only at clk edges.
REQ-016 IDLE+start+MTHI/MTLO: HI (resp. LO) takes a at the next edge; the other half is unchanged; busy stays 0; done pulses the following cycle.
REQ-017 IDLE+start+MULT/MULTU: latch operands, enter MUL, busy=1 from next cycle.
REQ-018 MUL: after MUL_LAT cycles write the full 2*DATA_W product; done=1 and busy=0 in cycle k+MUL_LAT, where k is the accept cycle.
REQ-019 MULT: signed two's-complement product. MULTU: unsigned product. No overflow is possible.
REQ-020 IDLE+start+DIV/DIVU: enter DIV and run a radix-2 restoring iteration.
REQ-021 DIV: 1 setup cycle plus DATA_W iterations; done=1 in cycle k+DATA_W+1, with LO=quotient and HI=remainder.
REQ-022 DIV signed: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-023 Divide by zero: no trap; fixed latency. LO=all-ones, HI=a.
REQ-024 Signed MIN/-1: LO=MIN, HI=0.
REQ-025 start while busy=1: ignored; no queueing.
REQ-026 Invalid op with start: ignored; no state change.
REQ-027 cancel while busy: return to IDLE next edge; no HI/LO write; no done.
REQ-028 cancel in IDLE: no effect on HI/LO.
REQ-029 cancel and start in the same cycle: cancel wins; start is dropped.
REQ-030 Completion cycle: a start issued in the done cycle is accepted, because busy=0 in that cycle.
REQ-031 hi/lo/hilo change only on a completed operation or MTHI/MTLO.

Reset
REQ-032 rst=1 at an edge: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
REQ-033 Reset mid-operation: the operation is discarded; no done pulse follows.
REQ-034 Reset is not asynchronous; outputs change only at the edge that samples rst.

Structure
REQ-035 Op codes, FSM state encodings and the divide-by-zero result constants live in the shared CPU defines package.
REQ-036 The iterative divider is sub-module div_core, holding DATA_W, the remainder/quotient shift registers and its counter.
REQ-037 The multiplier is inline: operand register, MUL_LAT-deep result pipeline and sign handling.

Verification (DATA_W=32, MUL_LAT=2)
REQ-038 MULT a=0xFFFFFFFE b=3 -> two cycles later, hilo=0xFFFFFFFF_FFFFFFFA and done for one cycle.
REQ-039 MULTU a=0xFFFFFFFE b=3 -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-040 DIV a=0xFFFFFFF9 (-7) b=2 -> cycle k+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234, same latency.
REQ-042 DIV started, cancel at iteration 10 -> busy=0 next cycle, no done, hi/lo unchanged; then MTHI a=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle, lo unchanged.
REQ-043 A second start while busy is ignored; rst during MUL -> all outputs 0 the next cycle and no done pulse.
